// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: fetch state encoding, default reset vector and 6502 operand-length decode
package instruction_fetch_pkg;
  typedef enum logic [2:0] {VEC_LO, VEC_HI, OPC, OPR1, OPR2, PRESENT, GAP} fetch_state_t;
  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'hFFFC;
  function automatic logic [1:0] operand_count(input logic [7:0] op);
    logic [2:0] mode;
    mode = op[4:2];
    if (op[1:0] == 2'b01) return (mode inside {3'b011, 3'b110, 3'b111}) ? 2'd2 : 2'd1;
    return (mode == 3'b011 || mode == 3'b111) ? 2'd2 :
           (mode == 3'b010 || mode == 3'b110) ? 2'd0 :
           (mode != 3'b000) ? 2'd1 :
           (op == 8'h20) ? 2'd2 : {1'b0, op[7]};
  endfunction
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: reads opcode plus operand bytes via a 2-cycle byte protocol and presents them to the decoder
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [REG_WIDTH-1:0]  mem_data_in,
  output logic [REG_WIDTH-1:0]  instruction_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  instruction_ready,
  input  logic                  instruction_done,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_val,
  output logic [ADDR_WIDTH-1:0] pc_out
);
  fetch_state_t state, state_d;
  logic half, half_d;
  logic [ADDR_WIDTH-1:0] pc, pc_d, opr, opr_d;
  logic [REG_WIDTH-1:0] instr, instr_d;
  logic [1:0] n, n_d;
  logic rd_state;
  assign rd_state = state != PRESENT && state != GAP;
  assign mem_rd = rd_state && !half && !reset;
  assign mem_addr = (!rd_state || reset) ? '0 :
                    state == VEC_LO ? RESET_VECTOR :
                    state == VEC_HI ? RESET_VECTOR + 1'b1 : pc;
  assign instruction_ready = state == PRESENT;
  assign instruction_out = instr;
  assign addr_out = opr;
  assign pc_out = pc;
  // half=0 is the strobe cycle, half=1 is the capture cycle of each byte
  always_comb begin
    state_d = state;
    half_d = rd_state ? !half : 1'b0;
    pc_d = pc;
    opr_d = opr;
    instr_d = instr;
    n_d = n;
    case (state)
      VEC_LO: if (half) begin
        pc_d = {pc[ADDR_WIDTH-1:REG_WIDTH], mem_data_in};
        state_d = VEC_HI;
      end
      VEC_HI: if (half) begin
        pc_d = ADDR_WIDTH'({mem_data_in, pc[REG_WIDTH-1:0]});
        state_d = OPC;
      end
      OPC: if (half) begin
        instr_d = mem_data_in;
        opr_d = '0;
        pc_d = pc + 1'b1;
        n_d = operand_count(8'(mem_data_in));
        state_d = operand_count(8'(mem_data_in)) == 2'd0 ? PRESENT : OPR1;
      end
      OPR1: if (half) begin
        opr_d = ADDR_WIDTH'(mem_data_in);
        pc_d = pc + 1'b1;
        state_d = n == 2'd2 ? OPR2 : PRESENT;
      end
      OPR2: if (half) begin
        opr_d = ADDR_WIDTH'({mem_data_in, opr[REG_WIDTH-1:0]});
        pc_d = pc + 1'b1;
        state_d = PRESENT;
      end
      PRESENT: if (instruction_done) begin
        pc_d = pc_load ? pc_load_val : pc;
        state_d = GAP;
      end
      GAP: state_d = OPC;
      default: state_d = VEC_LO;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= VEC_LO;
      half <= 1'b0;
      pc <= '0;
      opr <= '0;
      instr <= '0;
      n <= '0;
    end else begin
      state <= state_d;
      half <= half_d;
      pc <= pc_d;
      opr <= opr_d;
      instr <= instr_d;
      n <= n_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of vector load, operand assembly, handshake, jumps, wrap and mid-fetch reset
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] mem_addr;
  logic mem_rd;
  logic [7:0] mem_data_in = 8'h00;
  logic [7:0] instruction_out;
  logic [15:0] addr_out;
  logic instruction_ready;
  logic instruction_done = 1'b0;
  logic pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0000;
  logic [15:0] pc_out;
  logic [7:0] mem [0:65535];
  logic [15:0] rd_q[$];
  logic prev_rd = 1'b0;
  int b2b_err = 0;
  int checks = 0;
  int errors = 0;
  int cyc;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data_in(mem_data_in), .instruction_out(instruction_out), .addr_out(addr_out),
    .instruction_ready(instruction_ready), .instruction_done(instruction_done),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .pc_out(pc_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_data_in <= mem[mem_addr];
  always @(negedge clk) begin
    if (mem_rd) rd_q.push_back(mem_addr);
    if (mem_rd && prev_rd) b2b_err++;
    prev_rd = mem_rd;
  end

  task automatic wait_ready(output int c);
    c = 0;
    while (c < 40) begin
      @(negedge clk);
      if (instruction_ready) break;
      c++;
    end
  endtask

  task automatic issue_done(input logic ld, input logic [15:0] val, input logic [15:0] exp_pc);
    instruction_done = 1'b1;
    pc_load = ld;
    pc_load_val = val;
    @(negedge clk);
    instruction_done = 1'b0;
    pc_load = 1'b0;
    checks++;
    if (instruction_ready !== 1'b0 || pc_out !== exp_pc) begin
      errors++;
      $display("FAIL done_release: ready=%b pc=%h expected ready=0 pc=%h", instruction_ready, pc_out, exp_pc);
    end
    rd_q.delete();
  endtask

  task automatic test_reset;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80; mem[16'h8000] = 8'hEA;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_rd, mem_addr, instruction_out, addr_out, instruction_ready, pc_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b addr=%h instr=%h opr=%h rdy=%b pc=%h expected all zero",
               mem_rd, mem_addr, instruction_out, addr_out, instruction_ready, pc_out);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    rd_q.delete();
    wait_ready(cyc);
    checks++;
    if (cyc !== 6) begin errors++; $display("FAIL reset_latency: got %0d expected 6", cyc); end
    checks++;
    if (rd_q.size() !== 3 || rd_q[0] !== 16'hFFFC || rd_q[1] !== 16'hFFFD || rd_q[2] !== 16'h8000) begin
      errors++;
      $display("FAIL reset_reads: got %0d reads first %h expected FFFC FFFD 8000", rd_q.size(), rd_q[0]);
    end
    checks++;
    if (instruction_out !== 8'hEA || addr_out !== 16'h0000 || pc_out !== 16'h8001) begin
      errors++;
      $display("FAIL reset_nop: instr=%h opr=%h pc=%h expected EA 0000 8001", instruction_out, addr_out, pc_out);
    end
  endtask

  task automatic test_lda_imm;
    mem[16'h8000] = 8'hA9; mem[16'h8001] = 8'h44;
    pc_load = 1'b1;
    pc_load_val = 16'h1234;
    repeat (2) @(negedge clk);
    pc_load = 1'b0;
    checks++;
    if (instruction_ready !== 1'b1 || pc_out !== 16'h8001) begin
      errors++;
      $display("FAIL load_without_done: rdy=%b pc=%h expected 1 8001", instruction_ready, pc_out);
    end
    issue_done(1'b1, 16'h8000, 16'h8000);
    wait_ready(cyc);
    checks++;
    if (cyc !== 4 || rd_q.size() !== 2 || rd_q[0] !== 16'h8000) begin
      errors++;
      $display("FAIL imm_timing: cyc=%0d reads=%0d first=%h expected 4 2 8000", cyc, rd_q.size(), rd_q[0]);
    end
    checks++;
    if (instruction_out !== 8'hA9 || addr_out !== 16'h0044 || pc_out !== 16'h8002) begin
      errors++;
      $display("FAIL imm_values: instr=%h opr=%h pc=%h expected A9 0044 8002", instruction_out, addr_out, pc_out);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (instruction_ready !== 1'b1 || addr_out !== 16'h0044 || instruction_out !== 8'hA9) begin
      errors++;
      $display("FAIL imm_hold: rdy=%b opr=%h instr=%h expected 1 0044 A9", instruction_ready, addr_out, instruction_out);
    end
  endtask

  task automatic test_lda_abs;
    mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h00; mem[16'h8002] = 8'h02;
    issue_done(1'b1, 16'h8000, 16'h8000);
    wait_ready(cyc);
    checks++;
    if (cyc !== 6) begin errors++; $display("FAIL abs_latency: got %0d expected 6", cyc); end
    checks++;
    if (instruction_out !== 8'hAD || addr_out !== 16'h0200 || pc_out !== 16'h8003) begin
      errors++;
      $display("FAIL abs_values: instr=%h opr=%h pc=%h expected AD 0200 8003", instruction_out, addr_out, pc_out);
    end
  endtask

  task automatic test_jump;
    mem[16'h9000] = 8'hEA;
    issue_done(1'b1, 16'h9000, 16'h9000);
    @(negedge clk);
    instruction_done = 1'b1;
    pc_load = 1'b1;
    pc_load_val = 16'h4444;
    @(negedge clk);
    instruction_done = 1'b0;
    pc_load = 1'b0;
    wait_ready(cyc);
    checks++;
    if (cyc !== 0 || rd_q.size() !== 1 || rd_q[0] !== 16'h9000) begin
      errors++;
      $display("FAIL jump_reads: cyc=%0d reads=%0d first=%h expected 0 1 9000", cyc, rd_q.size(), rd_q[0]);
    end
    checks++;
    if (instruction_out !== 8'hEA || pc_out !== 16'h9001) begin
      errors++;
      $display("FAIL jump_values: instr=%h pc=%h expected EA 9001", instruction_out, pc_out);
    end
  endtask

  task automatic test_back_to_back;
    mem[16'hA000] = 8'hEA;
    issue_done(1'b1, 16'hA000, 16'hA000);
    instruction_done = 1'b1;
    pc_load = 1'b1;
    pc_load_val = 16'hA000;
    wait_ready(cyc);
    checks++;
    if (cyc !== 2 || pc_out !== 16'hA001) begin
      errors++;
      $display("FAIL b2b_first: cyc=%0d pc=%h expected 2 A001", cyc, pc_out);
    end
    @(negedge clk);
    instruction_done = 1'b0;
    pc_load = 1'b0;
    checks++;
    if (instruction_ready !== 1'b0 || pc_out !== 16'hA000) begin
      errors++;
      $display("FAIL b2b_accept: rdy=%b pc=%h expected 0 A000", instruction_ready, pc_out);
    end
    wait_ready(cyc);
    checks++;
    if (cyc !== 2 || instruction_out !== 8'hEA || pc_out !== 16'hA001) begin
      errors++;
      $display("FAIL b2b_second: cyc=%0d instr=%h pc=%h expected 2 EA A001", cyc, instruction_out, pc_out);
    end
  endtask

  task automatic test_wrap;
    mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h77;
    issue_done(1'b1, 16'hFFFF, 16'hFFFF);
    wait_ready(cyc);
    checks++;
    if (cyc !== 4 || rd_q.size() !== 2 || rd_q[0] !== 16'hFFFF || rd_q[1] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_reads: cyc=%0d reads=%0d second=%h expected 4 2 0000", cyc, rd_q.size(), rd_q[1]);
    end
    checks++;
    if (instruction_out !== 8'hA9 || addr_out !== 16'h0077 || pc_out !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_values: instr=%h opr=%h pc=%h expected A9 0077 0001", instruction_out, addr_out, pc_out);
    end
  endtask

  task automatic test_reset_mid;
    issue_done(1'b1, 16'h8000, 16'h8000);
    repeat (5) @(negedge clk);
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'h8002) begin
      errors++;
      $display("FAIL opr2_read: rd=%b addr=%h expected 1 8002", mem_rd, mem_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_addr, instruction_out, addr_out, instruction_ready, pc_out} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: rd=%b addr=%h instr=%h opr=%h rdy=%b pc=%h expected all zero",
               mem_rd, mem_addr, instruction_out, addr_out, instruction_ready, pc_out);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    rd_q.delete();
    wait_ready(cyc);
    checks++;
    if (cyc !== 10 || rd_q.size() !== 5 || rd_q[0] !== 16'hFFFC) begin
      errors++;
      $display("FAIL midreset_reads: cyc=%0d reads=%0d first=%h expected 10 5 FFFC", cyc, rd_q.size(), rd_q[0]);
    end
    checks++;
    if (instruction_out !== 8'hAD || addr_out !== 16'h0200 || pc_out !== 16'h8003) begin
      errors++;
      $display("FAIL midreset_values: instr=%h opr=%h pc=%h expected AD 0200 8003", instruction_out, addr_out, pc_out);
    end
  endtask

  task automatic test_protocol;
    checks++;
    if (b2b_err !== 0) begin
      errors++;
      $display("FAIL rd_back_to_back: got %0d consecutive strobes expected 0", b2b_err);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset;
    test_lda_imm;
    test_lda_abs;
    test_jump;
    test_back_to_back;
    test_wrap;
    test_reset_mid;
    test_protocol;
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end
endmodule
